line_writeback_writer: RTL and testbench
========================================

Name: line_writeback_writer

Overview:
- Memory-side writer that pushes 64-byte cache lines back to DRAM over the shared memory bus.
- It is the write counterpart of the line reader used by the cache fill path.
- A cache or its eviction logic hands over a line address plus 512 bits of data through a ready/valid handshake. The block buffers up to DEPTH lines and serialises each one onto the bus as 1 address beat followed by 8 data beats.
- It sits between the data cache and the bus mux, on the bus mux's write-side port.

Parameters:
- DEPTH, 2, number of line buffer entries (power of 2, at least 1).
- TAGID, 8'h00, low 8 bits of bus_reqtag; identifies this requester on the bus.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- wr_reqcyc  in  1  line write request valid.
- wr_ready  out  1  buffer can accept a line this cycle.
- wr_addr  in  64  line address; bits [5:0] are ignored and forced to 0.
- wr_data  in  512 ([0:511])  line data; word k = bits [64k : 64k+63], k = 0..7.
- wr_respcyc  out  1  one-cycle pulse: one line has been fully accepted by the bus.
- wr_busy  out  1  buffer non-empty or a transfer is in progress.
- bus_reqcyc  out  1  bus request valid.
- bus_req  out  64  address beat or data beat.
- bus_reqtag  out  13  {1'b1 write, 4'h1 memory, TAGID}.
- bus_reqack  in  1  bus accepted the current beat.
- bus_respcyc  in  1  ignored; writes receive no response.
- bus_respack  out  1  tied to 0.

Behaviour:
- Reset (synchronous): on the next edge, FIFO count = 0, head/tail pointers = 0, state = IDLE, beat = 0. All outputs become 0 except wr_ready, which becomes 1.
- Reset mid-transfer: the in-flight line and all buffered lines are dropped and no wr_respcyc is issued. bus_reqcyc is low in the cycle after the reset edge.
- FIFO storage: DEPTH entries of {addr[63:6], data[0:511]}.
- Push: occurs when wr_reqcyc && wr_ready.
- wr_ready = (count != DEPTH). It is combinational from registered count only, so a pop in the same cycle does not raise it.
- Simultaneous push and pop (not full): count is unchanged; the pushed entry lands at the tail.
- wr_reqcyc while full: not accepted and no state change. The requester must hold its request.
- State machine (IDLE, ADDR, DATA):
  - IDLE: bus_reqcyc = 0. If count != 0, go to ADDR on the next edge; the earliest address beat is the cycle after a push into an empty FIFO.
  - ADDR: bus_reqcyc = 1, bus_req = {head.addr, 6'b0}. Held stable until bus_reqack. On ack, go to DATA with beat = 0.
  - DATA: bus_reqcyc = 1, bus_req = head.data word[beat]. Held stable until bus_reqack. On ack with beat < 7, increment beat.
  - DATA, ack on beat == 7: pop the head and pulse wr_respcyc = 1 in the next cycle (registered). Next state is ADDR if count after the pop is nonzero, otherwise IDLE.
- bus_reqcyc stays high across consecutive beats of one line. It drops for at least the IDLE cycle only when the FIFO empties.
- Minimum latency with acks every cycle: push at cycle 0, address at cycle 1, data at cycles 2–9, wr_respcyc at cycle 10.
- Ack stalls: any number of cycles with bus_reqack = 0 hold bus_req and bus_reqtag unchanged.
- The beat counter is 3 bits and wraps 7 → 0 only on a line pop.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- wr_busy = (count != 0) || (state != IDLE).
- bus_respcyc has no effect on any state.

Decomposition:
- Shared package (mem_bus_pkg) holds:
  - bus tag field constants: WRITE bit position, MEM type 4'h1;
  - LINE_BYTES = 64, WORDS_PER_LINE = 8;
  - the writer state enum.
- One natural sub-module: line_fifo (parameterised DEPTH × 570-bit synchronous FIFO with push/pop/count). The FSM and beat mux stay in the top module.

Test Plan:
- Single line, ack every cycle: addr 0x1000_0047, data words 0x0..0x7 → address beat 0x1000_0040, then data beats 0..7 in order; wr_respcyc pulses exactly once, 10 cycles after the push; wr_busy drops the cycle after.
- Backpressure: bus_reqack low for 3 cycles on the address beat and on beat 4 → bus_req held constant during the stalls; 8 data beats total; bus_reqtag = 13'h1100 | TAGID throughout.
- Fill to full (DEPTH = 2): push 3 lines back-to-back with acks off → wr_ready = 0 after the 2nd push; the 3rd request is held. Enabling acks → lines drain in push order, two wr_respcyc pulses, the 3rd push is accepted on the cycle after the first pop, and bus_reqcyc goes directly DATA → ADDR with no gap.
- Simultaneous push and pop at count = 1 → count stays 1 and the new line's address beat follows immediately after the old line's beat 7.
- Reset asserted during beat 3 with 1 line buffered → next cycle bus_reqcyc = 0, wr_ready = 1, wr_busy = 0; no wr_respcyc; a subsequent push restarts from the address beat.
- bus_respcyc toggled randomly throughout the above → identical beat sequence; bus_respack stays 0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: request tag fields, line geometry and the
// state encoding of the line writeback writer.
package mem_bus_pkg;

  localparam int         TAG_WRITE_BIT  = 12;
  localparam logic [3:0] TAG_TYPE_MEM   = 4'h1;
  localparam int         LINE_BYTES     = 64;
  localparam int         WORDS_PER_LINE = 8;
  localparam int         LINE_ADDR_W    = 58;
  localparam int         LINE_DATA_W    = LINE_BYTES * 8;
  localparam int         LINE_ENTRY_W   = LINE_ADDR_W + LINE_DATA_W;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_ADDR,
    WB_DATA
  } wb_state_e;

  function automatic logic [12:0] write_tag(input logic [7:0] tagid);
    logic [12:0] tag;
    tag = {1'b0, TAG_TYPE_MEM, tagid};
    tag[TAG_WRITE_BIT] = 1'b1;
    return tag;
  endfunction

endpackage

// File: rtl/line_fifo.sv
// Synchronous FIFO of whole cache lines; the head entry is readable
// combinationally so the bus beat mux sees it the cycle it is written.
module line_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 570,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= (tail_reg == LAST_PTR) ? '0 : tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_reg <= (head_reg == LAST_PTR) ? '0 : head_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem[head_reg];
  assign count     = count_reg;

endmodule

// File: rtl/line_writeback_writer.sv
// Buffers evicted cache lines and serialises each onto the memory bus as one
// address beat followed by eight 64-bit data beats.
module line_writeback_writer
  import mem_bus_pkg::*;
#(
  parameter int         DEPTH = 2,
  parameter logic [7:0] TAGID = 8'h00
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_reqcyc,
  output logic          wr_ready,
  input  logic [63:0]   wr_addr,
  input  logic [0:511]  wr_data,
  output logic          wr_respcyc,
  output logic          wr_busy,
  output logic          bus_reqcyc,
  output logic [63:0]   bus_req,
  output logic [12:0]   bus_reqtag,
  input  logic          bus_reqack,
  input  logic          bus_respcyc,
  output logic          bus_respack
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_state_e             state_reg, state_next;
  logic [2:0]            beat_reg, beat_next;
  logic                  resp_reg, resp_next;
  logic                  push, pop;
  logic [CNT_W-1:0]      count;
  logic [LINE_ENTRY_W-1:0] head_entry;
  logic [LINE_ADDR_W-1:0]  head_addr;
  logic [0:511]            head_line;
  logic                    unused_inputs;

  assign unused_inputs = ^{bus_respcyc, wr_addr[5:0]};

  assign wr_ready = (count != CNT_W'(DEPTH));
  assign push     = wr_reqcyc && wr_ready;

  line_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LINE_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({wr_addr[63:6], wr_data}),
    .pop       (pop),
    .head_data (head_entry),
    .count     (count)
  );

  assign head_addr = head_entry[LINE_ENTRY_W-1 -: LINE_ADDR_W];
  assign head_line = head_entry[LINE_DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= WB_IDLE;
      beat_reg  <= '0;
      resp_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      resp_reg  <= resp_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    resp_next  = 1'b0;
    pop        = 1'b0;
    bus_reqcyc = 1'b0;
    bus_req    = '0;
    case (state_reg)
      WB_IDLE: begin
        // Leaving on the push itself puts the address beat one cycle after it.
        if (count != '0 || push) begin
          state_next = WB_ADDR;
        end
      end
      WB_ADDR: begin
        bus_reqcyc = 1'b1;
        bus_req    = {head_addr, 6'b0};
        if (bus_reqack) begin
          state_next = WB_DATA;
          beat_next  = '0;
        end
      end
      WB_DATA: begin
        bus_reqcyc = 1'b1;
        bus_req    = head_line[{beat_reg, 6'b0} +: 64];
        if (bus_reqack) begin
          if (beat_reg == 3'd7) begin
            pop        = 1'b1;
            resp_next  = 1'b1;
            beat_next  = '0;
            state_next = (count > CNT_W'(1) || push) ? WB_ADDR : WB_IDLE;
          end else begin
            beat_next = beat_reg + 3'd1;
          end
        end
      end
      default: state_next = WB_IDLE;
    endcase
  end

  assign bus_reqtag  = bus_reqcyc ? write_tag(TAGID) : '0;
  assign bus_respack = 1'b0;
  assign wr_respcyc  = resp_reg;
  assign wr_busy     = (count != '0) || (state_reg != WB_IDLE);

endmodule

// File: tb/tb_line_writeback_writer.sv
// Scenario bench for the line writeback writer: expected bus beats are queued
// at push time and checked by a negedge monitor as the bus accepts them.
module tb_line_writeback_writer;

  localparam int         DEPTH   = 2;
  localparam logic [7:0] TAGID   = 8'h5A;
  localparam logic [12:0] EXP_TAG = 13'h1100 | 13'(TAGID);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_reqcyc;
  logic          wr_ready;
  logic [63:0]   wr_addr;
  logic [0:511]  wr_data;
  logic          wr_respcyc;
  logic          wr_busy;
  logic          bus_reqcyc;
  logic [63:0]   bus_req;
  logic [12:0]   bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic          bus_respack;

  int tests_run    = 0;
  int tests_failed = 0;
  int accepted     = 0;
  int resp_count   = 0;
  int stall_cycles = 0;
  int busy_gaps    = 0;

  logic [63:0] sb_q[$];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_req;
  logic [12:0] prev_tag;

  line_writeback_writer #(
    .DEPTH (DEPTH),
    .TAGID (TAGID)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_reqcyc   (wr_reqcyc),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_respcyc  (wr_respcyc),
    .wr_busy     (wr_busy),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_respack (bus_respack)
  );

  always #5 clk = ~clk;

  initial begin
    bus_respcyc = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_respcyc = 1'($urandom_range(0, 1));
    end
  end

  // Bus monitor: beat order, stall stability, tag, response pulses.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests_run++;
        if (bus_reqcyc !== 1'b1 || bus_req !== prev_req || bus_reqtag !== prev_tag) begin
          tests_failed++;
          $display("FAIL stall_hold: reqcyc=%b req=%h tag=%h, required reqcyc=1 req=%h tag=%h",
                   bus_reqcyc, bus_req, bus_reqtag, prev_req, prev_tag);
        end
      end
      if (bus_reqcyc === 1'b1) begin
        tests_run++;
        if (bus_reqtag !== EXP_TAG) begin
          tests_failed++;
          $display("FAIL reqtag: got %h, required %h", bus_reqtag, EXP_TAG);
        end
        if (bus_reqack) begin
          tests_run++;
          if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_beat: got %h, required no beat", bus_req);
          end else begin
            logic [63:0] exp_beat;
            exp_beat = sb_q.pop_front();
            if (bus_req !== exp_beat) begin
              tests_failed++;
              $display("FAIL beat: got %h, required %h", bus_req, exp_beat);
            end else begin
              $display("[TB] beat accepted %h", bus_req);
            end
          end
          accepted++;
        end else begin
          stall_cycles++;
        end
      end
      if (wr_busy === 1'b1 && bus_reqcyc !== 1'b1) busy_gaps++;
      if (wr_respcyc === 1'b1) resp_count++;
      if (bus_respack !== 1'b0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL respack: got %b, required 0", bus_respack);
      end
      prev_stall = (bus_reqcyc === 1'b1) && !bus_reqack;
      prev_req   = bus_req;
      prev_tag   = bus_reqtag;
    end
  end

  function automatic logic [0:511] rand_line();
    logic [0:511] d;
    for (int k = 0; k < 8; k++) d[64*k +: 64] = {$urandom, $urandom};
    return d;
  endfunction

  task automatic do_push(input logic [63:0] a, input logic [0:511] d,
                         output logic resp_seen);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    resp_seen = 1'b0;
    wr_reqcyc = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = wr_ready;
      resp_seen = wr_respcyc;
      @(posedge clk);
      #1;
      n++;
    end
    wr_reqcyc = 1'b0;
    tests_run++;
    if (!acc) begin
      tests_failed++;
      $display("FAIL push_timeout: accepted=0, required 1 (addr %h)", a);
    end else begin
      sb_q.push_back({a[63:6], 6'b0});
      for (int k = 0; k < 8; k++) sb_q.push_back(d[64*k +: 64]);
      $display("[TB] pushed line addr %h", a);
    end
  endtask

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (resp_count < target && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    tests_run++;
    if (resp_count < target) begin
      tests_failed++;
      $display("FAIL resp_timeout: got %0d responses, required %0d", resp_count, target);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_reqcyc = 1'b0; wr_addr = '0; wr_data = '0; bus_reqack = 1'b0;
    step(2);
    tests_run++;
    if ({wr_ready, wr_busy, wr_respcyc, bus_reqcyc, bus_req, bus_reqtag, bus_respack} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 13'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b busy=%b resp=%b reqcyc=%b req=%h tag=%h, required 1 0 0 0 0 0",
               wr_ready, wr_busy, wr_respcyc, bus_reqcyc, bus_req, bus_reqtag);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_single();
    logic [0:511] d;
    logic rs;
    int base;
    for (int k = 0; k < 8; k++) d[64*k +: 64] = 64'(k);
    bus_reqack = 1'b1;
    base = resp_count;
    do_push(64'h1000_0047, d, rs);
    tests_run++;
    if (bus_reqcyc !== 1'b1 || bus_req !== 64'h1000_0040) begin
      tests_failed++;
      $display("FAIL single_addr_cycle1: reqcyc=%b req=%h, required 1 1000000040", bus_reqcyc, bus_req);
    end
    step(9);
    tests_run++;
    if (wr_respcyc !== 1'b1 || wr_busy !== 1'b0 || bus_reqcyc !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_resp_cycle10: resp=%b busy=%b reqcyc=%b, required 1 0 0",
               wr_respcyc, wr_busy, bus_reqcyc);
    end
    step(4);
    tests_run++;
    if (resp_count - base !== 1) begin
      tests_failed++;
      $display("FAIL single_resp_count: got %0d, required 1", resp_count - base);
    end
  endtask

  task automatic test_backpressure();
    logic rs;
    int start, idx, last_idx, stall, sbase, rbase;
    bus_reqack = 1'b0;
    rbase = resp_count;
    do_push(64'hDEAD_BEEF_0000_1FC0, rand_line(), rs);
    start = accepted; sbase = stall_cycles; last_idx = -1; stall = 0;
    for (int n = 0; n < 100; n++) begin
      idx = accepted - start;
      if (idx >= 9) break;
      if (idx != last_idx) begin stall = 0; last_idx = idx; end
      if ((idx == 0 || idx == 5) && stall < 3) begin
        bus_reqack = 1'b0; stall++;
      end else begin
        bus_reqack = 1'b1;
      end
      step(1);
    end
    bus_reqack = 1'b1;
    wait_resp(rbase + 1);
    tests_run++;
    if (stall_cycles - sbase !== 6 || accepted - start !== 9) begin
      tests_failed++;
      $display("FAIL backpressure_counts: stalls=%0d beats=%0d, required 6 9",
               stall_cycles - sbase, accepted - start);
    end
  endtask

  task automatic test_fill();
    logic rs;
    logic [0:511] dc;
    int rbase, gbase;
    bus_reqack = 1'b0;
    rbase = resp_count;
    gbase = busy_gaps;
    do_push(64'h0000_0000_0000_2000, rand_line(), rs);
    do_push(64'h0000_0000_0000_3000, rand_line(), rs);
    tests_run++;
    if (wr_ready !== 1'b0 || bus_reqcyc !== 1'b1 || bus_req !== 64'h2000) begin
      tests_failed++;
      $display("FAIL fill_full: ready=%b reqcyc=%b req=%h, required 0 1 2000", wr_ready, bus_reqcyc, bus_req);
    end
    dc = rand_line();
    wr_reqcyc = 1'b1; wr_addr = 64'h4000; wr_data = dc;
    step(3);
    tests_run++;
    if (wr_ready !== 1'b0 || wr_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_held: ready=%b busy=%b, required 0 1", wr_ready, wr_busy);
    end
    bus_reqack = 1'b1;
    do_push(64'h4000, dc, rs);
    tests_run++;
    if (rs !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_third_after_pop: resp in accept cycle=%b, required 1", rs);
    end
    wait_resp(rbase + 3);
    tests_run++;
    if (busy_gaps - gbase !== 0) begin
      tests_failed++;
      $display("FAIL fill_no_gap: idle-while-busy cycles=%0d, required 0", busy_gaps - gbase);
    end
  endtask

  task automatic test_back_to_back();
    logic rs;
    int rbase;
    bus_reqack = 1'b1;
    rbase = resp_count;
    do_push(64'h0000_0001_0000_0000, rand_line(), rs);
    step(8);
    do_push(64'h0000_0002_0000_0080, rand_line(), rs);
    tests_run++;
    if (bus_reqcyc !== 1'b1 || bus_req !== 64'h0000_0002_0000_0080 ||
        wr_respcyc !== 1'b1 || wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL push_pop_same_cycle: reqcyc=%b req=%h resp=%b ready=%b, required 1 0000000200000080 1 1",
               bus_reqcyc, bus_req, wr_respcyc, wr_ready);
    end
    wait_resp(rbase + 2);
  endtask

  task automatic test_reset_mid();
    logic rs;
    int rbase;
    bus_reqack = 1'b1;
    do_push(64'h0000_0000_0000_5000, rand_line(), rs);
    do_push(64'h0000_0000_0000_6000, rand_line(), rs);
    step(3);
    reset = 1'b1;
    bus_reqack = 1'b0;
    step(1);
    reset = 1'b0;
    tests_run++;
    if (bus_reqcyc !== 1'b0 || wr_ready !== 1'b1 || wr_busy !== 1'b0 || wr_respcyc !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: reqcyc=%b ready=%b busy=%b resp=%b, required 0 1 0 0",
               bus_reqcyc, wr_ready, wr_busy, wr_respcyc);
    end
    sb_q.delete();
    rbase = resp_count;
    step(5);
    tests_run++;
    if (resp_count !== rbase || bus_reqcyc !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_quiet: responses=%0d reqcyc=%b, required 0 0", resp_count - rbase, bus_reqcyc);
    end
    bus_reqack = 1'b1;
    do_push(64'h0000_0000_0000_7000, rand_line(), rs);
    tests_run++;
    if (bus_reqcyc !== 1'b1 || bus_req !== 64'h7000) begin
      tests_failed++;
      $display("FAIL reset_restart: reqcyc=%b req=%h, required 1 7000", bus_reqcyc, bus_req);
    end
    wait_resp(rbase + 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    step(3);
    tests_run++;
    if (sb_q.size() != 0 || busy_gaps != 0) begin
      tests_failed++;
      $display("FAIL drain: beats left=%0d gaps=%0d, required 0 0", sb_q.size(), busy_gaps);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
